// File: rtl/systolic_pkg.sv
// Shared constants, feeder state type and matrix packing helper for the
// 3x3 systolic array front end.
package systolic_pkg;

  localparam int unsigned N          = 3;
  localparam int unsigned FEED_STEPS = 2 * N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

  // Flat element index of M[r][c] inside a packed N*N matrix bus.
  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c);
    return r * N + c;
  endfunction

endpackage

// File: rtl/systolic_feeder_lane.sv
// One skewed output stream: picks the element for step t from the stored
// matrix along its row (A lanes) or column (B lanes), zero otherwise.
module feeder_lane
  import systolic_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned LANE      = 0,
  parameter bit          IS_COL    = 1'b0
) (
  input  logic [N*N*DATAWIDTH-1:0] mat,
  input  logic [2:0]               step,
  input  logic                     active,
  output logic [DATAWIDTH-1:0]     lane_out
);

  // Lane LANE carries element k of its row/column at step LANE+k.
  always_comb begin
    lane_out = '0;
    if (active) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (32'(step) == LANE + k) begin
          lane_out = IS_COL ? mat[elem_idx(k, LANE)*DATAWIDTH +: DATAWIDTH]
                            : mat[elem_idx(LANE, k)*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the 3x3 systolic array: captures a matrix pair, emits
// diagonally skewed row/column streams, then holds start through a zero drain.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*N*DATAWIDTH-1:0] A_mat,
  input  logic [N*N*DATAWIDTH-1:0] B_mat,
  output logic                     start,
  output logic [DATAWIDTH-1:0]     A0,
  output logic [DATAWIDTH-1:0]     A1,
  output logic [DATAWIDTH-1:0]     A2,
  output logic [DATAWIDTH-1:0]     B0,
  output logic [DATAWIDTH-1:0]     B1,
  output logic [DATAWIDTH-1:0]     B2,
  output logic                     busy
);

  localparam int unsigned MW         = N * N * DATAWIDTH;
  localparam logic [2:0]  T_LAST     = 3'(FEED_STEPS - 1);
  localparam logic [3:0]  DRAIN_LAST = 4'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

  feeder_state_e   state_q, state_d;
  logic [2:0]      t_q, t_d;
  logic [3:0]      drain_q, drain_d;
  logic [MW-1:0]   a_q, a_d;
  logic [MW-1:0]   b_q, b_d;
  logic            rst_q;
  logic            feeding;

  // in_ready is held low for the cycle after any reset edge so it stays
  // a pure function of registered state.
  assign in_ready = (state_q == IDLE) && !rst_q;
  assign busy     = (state_q != IDLE);
  assign start    = busy;
  assign feeding  = (state_q == FEED);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drain_d = drain_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = FEED;
          t_d     = '0;
          a_d     = A_mat;
          b_d     = B_mat;
        end
      end
      FEED: begin
        if (t_q == T_LAST) begin
          t_d = '0;
          if (DRAIN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      t_q     <= '0;
      drain_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drain_q <= drain_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rst_q   <= 1'b0;
    end
  end

  logic [DATAWIDTH-1:0] a_lane [N];
  logic [DATAWIDTH-1:0] b_lane [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    feeder_lane #(
      .DATAWIDTH (DATAWIDTH),
      .LANE      (i),
      .IS_COL    (1'b0)
    ) u_row (
      .mat      (a_q),
      .step     (t_q),
      .active   (feeding),
      .lane_out (a_lane[i])
    );
    feeder_lane #(
      .DATAWIDTH (DATAWIDTH),
      .LANE      (i),
      .IS_COL    (1'b1)
    ) u_col (
      .mat      (b_q),
      .step     (t_q),
      .active   (feeding),
      .lane_out (b_lane[i])
    );
  end

  assign A0 = a_lane[0];
  assign A1 = a_lane[1];
  assign A2 = a_lane[2];
  assign B0 = b_lane[0];
  assign B1 = b_lane[1];
  assign B2 = b_lane[2];

endmodule
